uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters.
- Each requester delivers a packet as a valid/ready byte stream with a last flag. The arbiter grants one requester per packet in round-robin order.
- Optionally prefixes each packet with a header byte carrying the requester ID.
- Drives the transmitter's byte-load handshake (tx_data/tx_en/tx_rdy) and sits directly in front of the transmitter in the UART subsystem.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).
- HEADER_EN, 1, 1 = send header byte {4'hA, id zero-extended to 4 bits} before each packet; 0 = no header.
- MAX_LEN, 64, maximum payload bytes per packet; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  NUM_REQ*8  per-requester byte; requester k occupies bits [8k+7:8k]
- req_last_i  in  NUM_REQ  marks the final byte of the packet; qualified by valid
- req_ready_o  out  NUM_REQ  per-requester byte accepted this cycle
- tx_data_o  out  8  byte to the transmitter
- tx_en_o  out  1  byte-load request to the transmitter
- tx_rdy_i  in  1  transmitter can load a byte; already includes CTS; a load occurs when tx_en_o & tx_rdy_i
- grant_o  out  NUM_REQ  one-hot current owner; all zeros when idle
- busy_o  out  1  a packet is in progress (state != IDLE)
- pkt_done_o  out  1  one-cycle pulse after a packet's final byte is loaded
- trunc_o  out  1  one-cycle pulse when a packet was cut at MAX_LEN

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; rr pointer=0; byte count=0.
  - All outputs 0, including grant_o, tx_en_o, req_ready_o, pulses.
  - Applies mid-packet with no flush; the transmitter shares rst and aborts too.
- States: IDLE, HDR, DATA.
- IDLE:
  - If any req_valid_i, select the first set requester searching upward from the rr pointer, wrapping at NUM_REQ-1 to 0.
  - Register grant one-hot. Next state is HDR if HEADER_EN, else DATA. byte count=0.
  - tx_en_o=0 in IDLE. Arbitration takes one cycle: the earliest tx_en_o is the cycle after valid is seen.
- HDR:
  - tx_en_o=1, tx_data_o=header.
  - On tx_en_o&tx_rdy_i go to DATA. Otherwise hold, including while CTS is deasserted.
- DATA (owner g):
  - tx_en_o=req_valid_i[g]; tx_data_o=req_data_i[g]; req_ready_o[g]=tx_rdy_i. Other ready bits are 0.
  - Each load increments byte count.
  - If a loaded byte has req_last_i[g]=1, or byte count reaches MAX_LEN on that load:
    - Go to IDLE and set rr pointer=g+1, wrapping.
    - pkt_done_o pulses the next cycle.
    - trunc_o pulses together with pkt_done_o when the cut was at MAX_LEN and last=0.
    - Remaining bytes of a truncated packet are treated as a new packet at the owner's next grant.
- Requester dropping valid mid-packet: grant is held indefinitely, with no timeout.
- Requesters must hold data and last stable while valid=1 and ready=0.
- Combinational paths:
  - tx_en_o and tx_data_o must not depend on tx_rdy_i, to avoid loops.
  - req_ready_o may depend on tx_rdy_i combinationally.
- Idle-cycle rule: the transmitter deasserts rdy for the full character after each load. The arbiter issues no back-to-back loads and needs no extra gap logic.
- Simultaneous requests in IDLE: round-robin order strictly. A requester asserting valid during another's packet waits until the next IDLE.
- grant_o and busy_o update on the same edge as the state register.

Test Plan:
- Single packet, HEADER_EN=1: req1 sends 0x11,0x22(last), with tx_rdy_i modelling a 10-bit character time → tx bytes 0xA1,0x11,0x22; pkt_done_o one pulse; grant_o=4'b0010 for the duration, then 0; busy_o=0 after.
- Fairness: req0, req2, req3 all hold 1-byte packets continuously, pointer=0 → grant order 0,2,3,0,2,3; each header matches its owner; no requester is served twice in a row while others wait.
- Backpressure: tx_rdy_i held 0 for 500 cycles during HDR and during DATA → tx_en_o stays 1, no ready pulses, no byte loss, data order preserved.
- Truncation, MAX_LEN=4: req2 sends 6 bytes with last on byte 6 → first packet 0xA2+4 bytes with trunc_o and pkt_done_o; next grant to req2 sends 0xA2+2 bytes with pkt_done_o only.
- Valid gap: owner deasserts valid 50 cycles mid-packet while req3 is valid → grant unchanged, tx_en_o=0 during the gap, req3 is served only after the owner's last.
- Reset mid-DATA: rst for 1 cycle after the 2nd payload byte → next cycle grant_o=0, busy_o=0, tx_en_o=0, rr pointer=0; the following request from req1 is granted with a fresh header.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte-stream requesters share one UART
// transmitter, one whole packet per grant, with an optional requester-ID header.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int HEADER_EN = 1,
    parameter int MAX_LEN   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_en_o,
    input  logic                 tx_rdy_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 pkt_done_o,
    output logic                 trunc_o
);

    // Handshakes: a requester byte moves when req_valid_i[k] & req_ready_o[k];
    // a transmitter load happens when tx_en_o & tx_rdy_i. Both complete on the
    // same edge in DATA because ready mirrors tx_rdy_i for the owner only.
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_rr, w_rr_nxt;
    logic [ID_W-1:0]    r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [7:0]         r_count, w_count_nxt;
    logic               r_pkt_done, w_pkt_done_nxt;
    logic               r_trunc, w_trunc_nxt;
    logic [ID_W-1:0]    w_pick;
    logic               w_pick_ok;
    logic               w_load;
    logic               w_last;
    logic               w_cut;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? ID_W'(v - NUM_REQ) : ID_W'(v);
    endfunction

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_pick    = '0;
        w_pick_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrap_idx(int'(r_rr) + i)]) begin
                w_pick    = wrap_idx(int'(r_rr) + i);
                w_pick_ok = 1'b1;
            end
        end
    end

    // tx_en_o/tx_data_o never look at tx_rdy_i, so no loop through the transmitter.
    always_comb begin
        tx_en_o     = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        case (r_state)
            S_HDR: begin
                tx_en_o   = 1'b1;
                tx_data_o = {4'hA, 4'(r_owner)};
            end
            S_DATA: begin
                tx_en_o              = req_valid_i[r_owner];
                tx_data_o            = req_data_i[{r_owner, 3'b000} +: 8];
                req_ready_o[r_owner] = tx_rdy_i;
            end
            default: ;
        endcase
    end

    assign w_load = tx_en_o & tx_rdy_i;
    assign w_last = req_last_i[r_owner];
    assign w_cut  = ((r_count + 8'd1) == 8'(MAX_LEN));

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_owner_nxt    = r_owner;
        w_grant_nxt    = r_grant;
        w_count_nxt    = r_count;
        w_pkt_done_nxt = 1'b0;
        w_trunc_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_ok) begin
                    w_owner_nxt = w_pick;
                    w_grant_nxt = NUM_REQ'(1) << w_pick;
                    w_count_nxt = 8'd0;
                    w_state_nxt = (HEADER_EN != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (w_load) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_load) begin
                    w_count_nxt = r_count + 8'd1;
                    if (w_last || w_cut) begin
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_rr_nxt       = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + ID_W'(1);
                        w_pkt_done_nxt = 1'b1;
                        w_trunc_nxt    = ~w_last;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_count    <= 8'd0;
            r_pkt_done <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_grant    <= w_grant_nxt;
            r_count    <= w_count_nxt;
            r_pkt_done <= w_pkt_done_nxt;
            r_trunc    <= w_trunc_nxt;
        end
    end

    assign grant_o    = r_grant;
    assign busy_o     = (r_state != S_IDLE);
    assign pkt_done_o = r_pkt_done;
    assign trunc_o    = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues, a transmitter that is busy
// for one character after each load, and an expected {grant, byte} stream.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CHAR    = 10;
    localparam int MAX_LEN = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_en_o;
    logic                 tx_rdy_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 busy_o;
    logic                 pkt_done_o;
    logic                 trunc_o;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(2), .HEADER_EN(1), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .tx_data_o(tx_data_o), .tx_en_o(tx_en_o), .tx_rdy_i(tx_rdy_i),
        .grant_o(grant_o), .busy_o(busy_o), .pkt_done_o(pkt_done_o), .trunc_o(trunc_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q[$];
    logic [8:0]  rmem [NUM_REQ][64];
    int          rhead [NUM_REQ];
    int          rtail [NUM_REQ];
    int          gap_idx [NUM_REQ];
    int          gap_left [NUM_REQ];
    int          busy_cnt = 0;
    logic        hold_low = 1'b0;
    logic        load_seen = 1'b0;
    logic [NUM_REQ-1:0] acc_seen = '0;
    int          n_done = 0;
    int          n_trunc = 0;
    int          n_orphan = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hdr(input int k);
        return {4'hA, 4'(k)};
    endfunction

    function automatic logic [3:0] onehot(input int k);
        return 4'(1 << k);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_byte(input int k, input logic [7:0] d, input logic last);
        rmem[k][rtail[k]] = {last, d};
        rtail[k]++;
    endtask

    task automatic exp_push(input int k, input logic [7:0] d);
        exp_q.push_back({onehot(k), d});
    endtask

    // Requesters and transmitter update just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rhead[k] = 0;
                rtail[k] = 0;
            end
            busy_cnt = 0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++)
                if (acc_seen[k]) rhead[k]++;
            if (load_seen) busy_cnt = CHAR;
            else if (busy_cnt > 0) busy_cnt--;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid_i[k] = (rhead[k] < rtail[k]);
            if (req_valid_i[k] && rhead[k] == gap_idx[k] && gap_left[k] > 0) begin
                req_valid_i[k] = 1'b0;
                gap_left[k]--;
            end
            req_data_i[8*k +: 8] = rmem[k][rhead[k]][7:0];
            req_last_i[k]        = rmem[k][rhead[k]][8];
        end
        tx_rdy_i = (busy_cnt == 0) && !hold_low;
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        load_seen = 1'b0;
        acc_seen  = '0;
        if (!rst) begin
            acc_seen = req_valid_i & req_ready_o;
            if (tx_en_o && tx_rdy_i) begin
                load_seen = 1'b1;
                if (exp_q.size() == 0) check("tx_unexpected", 32'(exp_q.size()), 1);
                else check("tx_byte", {20'h0, grant_o, tx_data_o}, {20'h0, exp_q.pop_front()});
            end
            if (pkt_done_o) n_done++;
            if (trunc_o) begin
                n_trunc++;
                if (!pkt_done_o) n_orphan++;
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hold_low = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gap_idx[k]  = -1;
            gap_left[k] = 0;
        end
        n_done = 0;
        n_trunc = 0;
        n_orphan = 0;
    endtask

    function automatic logic all_sent();
        for (int k = 0; k < NUM_REQ; k++)
            if (rhead[k] != rtail[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o && all_sent()) break;
        end
        repeat (3) @(negedge clk);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_grant"}, 32'(grant_o), 0);
    endtask

    task automatic wait_q_size(input int n, input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == n) break;
        end
        check(tag, 32'(exp_q.size()), 32'(n));
    endtask

    task automatic wait_rhead(input int k, input int n, input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rhead[k] == n) break;
        end
        check(tag, 32'(rhead[k]), 32'(n));
    endtask

    // ---------------- tests ----------------
    initial begin
        logic [7:0] d;
        logic [7:0] b2;
        rst = 1'b1;
        req_valid_i = '0;
        req_data_i = '0;
        req_last_i = '0;
        tx_rdy_i = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            rhead[k] = 0;
            rtail[k] = 0;
            gap_idx[k] = -1;
            gap_left[k] = 0;
        end
        do_reset();

        // reset state
        check("rst_grant", 32'(grant_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_tx_en", 32'(tx_en_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_done", 32'(pkt_done_o), 0);
        check("rst_trunc", 32'(trunc_o), 0);

        // single packet from requester 1
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b1);
        exp_push(1, hdr(1));
        exp_push(1, 8'h11);
        exp_push(1, 8'h22);
        drain("single");
        check("single_done", 32'(n_done), 1);
        check("single_trunc", 32'(n_trunc), 0);

        // fairness across requesters 0, 2, 3
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 3; j++) begin
                int k;
                k = (j == 0) ? 0 : j + 1;
                d = 8'($urandom_range(0, 255));
                push_byte(k, d, 1'b1);
                exp_push(k, hdr(k));
                exp_push(k, d);
            end
        end
        drain("fair");
        check("fair_done", 32'(n_done), 6);

        // backpressure in HDR and in DATA
        do_reset();
        hold_low = 1'b1;
        d  = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        push_byte(1, d, 1'b0);
        push_byte(1, b2, 1'b0);
        push_byte(1, 8'h5C, 1'b1);
        exp_push(1, hdr(1));
        exp_push(1, d);
        exp_push(1, b2);
        exp_push(1, 8'h5C);
        repeat (500) @(negedge clk);
        check("bp_hdr_en", 32'(tx_en_o), 1);
        check("bp_hdr_data", 32'(tx_data_o), 32'(hdr(1)));
        check("bp_hdr_ready", 32'(req_ready_o), 0);
        check("bp_hdr_q", 32'(exp_q.size()), 4);
        hold_low = 1'b0;
        wait_q_size(2, "bp_first_data");
        hold_low = 1'b1;
        repeat (500) @(negedge clk);
        check("bp_data_en", 32'(tx_en_o), 1);
        check("bp_data_hold", 32'(tx_data_o), 32'(b2));
        check("bp_data_ready", 32'(req_ready_o), 0);
        check("bp_data_q", 32'(exp_q.size()), 2);
        hold_low = 1'b0;
        drain("bp");

        // truncation at MAX_LEN
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            push_byte(2, d, (i == 5));
            if (i == 0 || i == MAX_LEN) exp_push(2, hdr(2));
            exp_push(2, d);
        end
        drain("trunc");
        check("trunc_done", 32'(n_done), 2);
        check("trunc_count", 32'(n_trunc), 1);
        check("trunc_with_done", 32'(n_orphan), 0);

        // owner valid gap while requester 3 waits; last coincides with MAX_LEN
        do_reset();
        gap_idx[0]  = 2;
        gap_left[0] = 50;
        exp_push(0, hdr(0));
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            push_byte(0, d, (i == 3));
            exp_push(0, d);
        end
        d = 8'($urandom_range(0, 255));
        push_byte(3, d, 1'b1);
        exp_push(3, hdr(3));
        exp_push(3, d);
        wait_rhead(0, 2, "gap_reach");
        repeat (20) @(negedge clk);
        check("gap_tx_en", 32'(tx_en_o), 0);
        check("gap_grant", 32'(grant_o), 32'(onehot(0)));
        check("gap_busy", 32'(busy_o), 1);
        check("gap_q", 32'(exp_q.size()), 4);
        drain("gap");
        check("gap_done", 32'(n_done), 2);
        check("gap_trunc", 32'(n_trunc), 0);

        // reset in the middle of a DATA phase
        do_reset();
        exp_push(1, hdr(1));
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            push_byte(1, d, (i == 3));
            if (i < 2) exp_push(1, d);
        end
        wait_rhead(1, 2, "mid_reach");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", 32'(grant_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_tx_en", 32'(tx_en_o), 0);
        check("mid_rst_q", 32'(exp_q.size()), 0);
        rst = 1'b0;
        n_done = 0;
        n_trunc = 0;
        d = 8'($urandom_range(0, 255));
        push_byte(1, d, 1'b1);
        exp_push(1, hdr(1));
        exp_push(1, d);
        b2 = 8'($urandom_range(0, 255));
        push_byte(3, b2, 1'b1);
        exp_push(3, hdr(3));
        exp_push(3, b2);
        drain("post_rst");
        check("post_rst_done", 32'(n_done), 2);
        check("post_rst_trunc", 32'(n_trunc), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
